// File: rtl/register_dispatch_pkg.sv
// Shared types and defaults for the register dispatch stage.
package register_dispatch_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_NREGS     = 32;
    localparam int unsigned DEF_NWB       = 2;
    localparam int unsigned DEF_PAYLOAD_W = 128;
    localparam bit          DEF_BYPASS    = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN         = 1'b0,
        ST_SERIAL_WAIT = 1'b1
    } dispatch_state_e;

    // Register-address width for a file of nregs entries.
    function automatic int unsigned reg_adr_w(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp.sv
// Multi-write-port register file with two combinational read ports and
// optional write-back forwarding; x0 reads as zero and ignores writes.
module regfile_mp
    import register_dispatch_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned NWB    = DEF_NWB,
    parameter bit          BYPASS = DEF_BYPASS,
    localparam int unsigned AW    = reg_adr_w(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWB-1:0]      wb_valid,
    input  logic [NWB*AW-1:0]   wb_adr,
    input  logic [NWB*XLEN-1:0] wb_data,
    input  logic [AW-1:0]       rs1_adr,
    input  logic [AW-1:0]       rs2_adr,
    output logic [XLEN-1:0]     rs1_data_c,
    output logic [XLEN-1:0]     rs2_data_c
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [AW-1:0]   rd_adr [2];
    logic [XLEN-1:0] rd_data [2];

    // Ascending port order makes the highest-index writer win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NWB); i++) begin
                if (wb_valid[i] && (wb_adr[i*AW +: AW] != '0)) begin
                    regs_q[wb_adr[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    assign rd_adr[0] = rs1_adr;
    assign rd_adr[1] = rs2_adr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_adr[p]];
            if (BYPASS) begin
                for (int i = 0; i < int'(NWB); i++) begin
                    if (wb_valid[i] && (wb_adr[i*AW +: AW] == rd_adr[p])) begin
                        rd_data[p] = wb_data[i*XLEN +: XLEN];
                    end
                end
            end
            if (rd_adr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

    assign rs1_data_c = rd_data[0];
    assign rs2_data_c = rd_data[1];

endmodule

// File: rtl/register_dispatch.sv
// Issue stage: scoreboarded operand read, serialisation FSM and a one-deep
// registered output stage towards the execution units.
module register_dispatch
    import register_dispatch_pkg::*;
#(
    parameter int unsigned XLEN      = DEF_XLEN,
    parameter int unsigned NREGS     = DEF_NREGS,
    parameter int unsigned NWB       = DEF_NWB,
    parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
    parameter bit          BYPASS    = DEF_BYPASS,
    localparam int unsigned AW       = reg_adr_w(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        in_rs1_ad,
    input  logic [AW-1:0]        in_rs2_ad,
    input  logic [AW-1:0]        in_rd,
    input  logic                 in_rs1_v,
    input  logic                 in_rs2_v,
    input  logic                 in_rd_v,
    input  logic                 in_serial,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1,
    output logic [XLEN-1:0]      out_rs2,
    output logic [AW-1:0]        out_rd,
    output logic                 out_rd_v,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic [NWB-1:0]       wb_valid,
    input  logic [NWB*AW-1:0]    wb_adr,
    input  logic [NWB*XLEN-1:0]  wb_data,
    input  logic                 serial_done,
    input  logic                 flush
);

    dispatch_state_e state_q, state_d;
    logic [NREGS-1:0] pend_q, pend_d, wb_hit, pend_clr;
    logic [XLEN-1:0]  rs1_data_c, rs2_data_c;
    logic             raw1, raw2, waw, hazard, accept;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NWB    (NWB),
        .BYPASS (BYPASS)
    ) u_rf (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_adr     (wb_adr),
        .wb_data    (wb_data),
        .rs1_adr    (in_rs1_ad),
        .rs2_adr    (in_rs2_ad),
        .rs1_data_c (rs1_data_c),
        .rs2_data_c (rs2_data_c)
    );

    // Registers targeted by any write-back port this cycle.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < int'(NWB); i++) begin
            if (wb_valid[i]) begin
                wb_hit[wb_adr[i*AW +: AW]] = 1'b1;
            end
        end
    end

    assign pend_clr = pend_q & ~wb_hit;

    // x0 never becomes pending, so no explicit zero-address guard is needed.
    always_comb begin
        raw1   = in_rs1_v && pend_q[in_rs1_ad] && !(BYPASS && wb_hit[in_rs1_ad]);
        raw2   = in_rs2_v && pend_q[in_rs2_ad] && !(BYPASS && wb_hit[in_rs2_ad]);
        waw    = in_rd_v && pend_clr[in_rd];
        hazard = raw1 || raw2 || waw;
    end

    assign in_ready = !rst && !flush && (state_q == ST_RUN) && !hazard
                      && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Set on accept beats a same-cycle write-back clear.
    always_comb begin
        pend_d = pend_clr;
        if (accept && in_rd_v && (in_rd != '0)) begin
            pend_d[in_rd] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && in_serial) begin
                    state_d = ST_SERIAL_WAIT;
                end
            end
            ST_SERIAL_WAIT: begin
                if (serial_done) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (flush) begin
            state_d = ST_RUN;
        end
    end

    // Output stage: load on accept, drain on out_ready, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_rd_v    <= 1'b0;
            out_payload <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_rs1     <= in_rs1_v ? rs1_data_c : '0;
            out_rs2     <= in_rs2_v ? rs2_data_c : '0;
            out_rd      <= in_rd;
            out_rd_v    <= in_rd_v;
            out_payload <= in_payload;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_dispatch.sv
// Directed and randomized check of register_dispatch against a behavioural model.
module tb_register_dispatch;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NWB = 2;
    localparam int unsigned PW = 128;
    localparam int unsigned AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [AW-1:0]     in_rs1_ad, in_rs2_ad, in_rd;
    logic              in_rs1_v, in_rs2_v, in_rd_v, in_serial;
    logic [PW-1:0]     in_payload;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   out_rs1, out_rs2;
    logic [AW-1:0]     out_rd;
    logic              out_rd_v;
    logic [PW-1:0]     out_payload;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*AW-1:0] wb_adr;
    logic [NWB*XLEN-1:0] wb_data;
    logic              serial_done, flush;

    register_dispatch #(
        .XLEN(XLEN), .NREGS(NREGS), .NWB(NWB), .PAYLOAD_W(PW), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_ad(in_rs1_ad), .in_rs2_ad(in_rs2_ad), .in_rd(in_rd),
        .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_rd_v(in_rd_v),
        .in_serial(in_serial), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_v(out_rd_v), .out_payload(out_payload),
        .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
        .serial_done(serial_done), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]  m_reg [32];
    bit           m_pend [32];
    bit           m_wait, m_ov;
    logic [31:0]  m_rs1, m_rs2;
    logic [4:0]   m_rd;
    logic         m_rdv;
    logic [127:0] m_pl;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] pl_a;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_wait = 1'b0; m_ov = 1'b0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rdv = 1'b0; m_pl = '0;
    endtask

    function automatic bit wb_hits(input logic [4:0] a);
        bit h = 1'b0;
        for (int i = 0; i < 2; i++)
            if (wb_valid[i] && wb_adr[i*5 +: 5] == a) h = 1'b1;
        return h;
    endfunction

    // Architectural value seen by a read this cycle: latest write-back wins.
    function automatic logic [31:0] mread(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_reg[a];
        for (int i = 0; i < 2; i++)
            if (wb_valid[i] && wb_adr[i*5 +: 5] == a) v = wb_data[i*32 +: 32];
        return v;
    endfunction

    task automatic idle();
        in_valid = 1'b0; in_rs1_ad = '0; in_rs2_ad = '0; in_rd = '0;
        in_rs1_v = 1'b0; in_rs2_v = 1'b0; in_rd_v = 1'b0; in_serial = 1'b0;
        in_payload = '0; out_ready = 1'b1; wb_valid = '0; wb_adr = '0;
        wb_data = '0; serial_done = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_out(input string pfx);
        chk({pfx, ".out_valid"}, 128'(out_valid), 128'(m_ov));
        chk({pfx, ".out_rs1"}, 128'(out_rs1), 128'(m_rs1));
        chk({pfx, ".out_rs2"}, 128'(out_rs2), 128'(m_rs2));
        chk({pfx, ".out_rd"}, 128'(out_rd), 128'(m_rd));
        chk({pfx, ".out_rd_v"}, 128'(out_rd_v), 128'(m_rdv));
        chk({pfx, ".out_payload"}, out_payload, m_pl);
    endtask

    // One clock: inputs already set at the falling edge.
    task automatic step(input string pfx);
        bit hz, rdy, acc;
        logic [31:0] r1, r2;
        #1;
        hz = (in_rs1_v && m_pend[in_rs1_ad] && !wb_hits(in_rs1_ad))
          || (in_rs2_v && m_pend[in_rs2_ad] && !wb_hits(in_rs2_ad))
          || (in_rd_v && m_pend[in_rd] && !wb_hits(in_rd));
        rdy = !flush && !m_wait && !hz && (!m_ov || out_ready);
        chk({pfx, ".in_ready"}, 128'(in_ready), 128'(rdy));
        acc = in_valid && rdy;
        r1 = in_rs1_v ? mread(in_rs1_ad) : 32'd0;
        r2 = in_rs2_v ? mread(in_rs2_ad) : 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (wb_valid[i] && wb_adr[i*5 +: 5] != 5'd0) m_reg[wb_adr[i*5 +: 5]] = wb_data[i*32 +: 32];
            if (wb_valid[i]) m_pend[wb_adr[i*5 +: 5]] = 1'b0;
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
            m_wait = 1'b0;
            m_ov = 1'b0;
        end else begin
            if (acc && in_rd_v && in_rd != 5'd0) m_pend[in_rd] = 1'b1;
            if (acc && in_serial) m_wait = 1'b1;
            else if (m_wait && serial_done) m_wait = 1'b0;
            if (acc) begin
                m_ov = 1'b1; m_rs1 = r1; m_rs2 = r2;
                m_rd = in_rd; m_rdv = in_rd_v; m_pl = in_payload;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk_out(pfx);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        #1;
        chk("reset.in_ready", 128'(in_ready), 128'd0);
        chk_out("reset");
        @(negedge clk);
        rst = 1'b0;

        // Write-back then read of x5
        idle(); wb_valid = 2'b01; wb_adr[4:0] = 5'd5; wb_data[31:0] = 32'h1234;
        step("wb_x5");
        idle(); in_valid = 1'b1; in_rs1_v = 1'b1; in_rs1_ad = 5'd5;
        in_payload = {$urandom, $urandom, $urandom, $urandom};
        step("rd_x5");
        chk("rd_x5.const_rs1", 128'(out_rs1), 128'(32'h1234));
        chk("rd_x5.const_valid", 128'(out_valid), 128'd1);

        // RAW on x3 resolved by same-cycle bypass from wb1
        idle(); in_valid = 1'b1; in_rd_v = 1'b1; in_rd = 5'd3;
        step("set_x3");
        idle(); in_valid = 1'b1; in_rs1_v = 1'b1; in_rs1_ad = 5'd3;
        #1 chk("raw_x3.const_block", 128'(in_ready), 128'd0);
        step("raw_x3_a");
        step("raw_x3_b");
        wb_valid = 2'b10; wb_adr[9:5] = 5'd3; wb_data[63:32] = 32'hBEEF;
        #1 chk("raw_x3.const_bypass_ready", 128'(in_ready), 128'd1);
        step("raw_x3_bp");
        chk("raw_x3.const_rs1", 128'(out_rs1), 128'(32'hBEEF));
        idle(); step("drain1");

        // Highest write port wins; x0 stays zero
        idle(); wb_valid = 2'b11; wb_adr = {5'd7, 5'd7}; wb_data = {32'd2, 32'd1};
        step("wb_x7");
        idle(); wb_valid = 2'b01; wb_adr[4:0] = 5'd0; wb_data[31:0] = 32'd5;
        step("wb_x0");
        idle(); in_valid = 1'b1; in_rs1_v = 1'b1; in_rs1_ad = 5'd7;
        in_rs2_v = 1'b1; in_rs2_ad = 5'd0;
        step("rd_x7_x0");
        chk("rd_x7.const", 128'(out_rs1), 128'd2);
        chk("rd_x0.const", 128'(out_rs2), 128'd0);

        // Serialising instruction
        idle(); in_valid = 1'b1; in_serial = 1'b1;
        step("serial_issue");
        idle(); in_valid = 1'b1; in_rs1_v = 1'b1; in_rs1_ad = 5'd5;
        for (int k = 0; k < 3; k++) begin
            serial_done = (k == 2);
            #1 chk("serial_wait.const_block", 128'(in_ready), 128'd0);
            step("serial_wait");
        end
        serial_done = 1'b0;
        #1 chk("serial_resume.const_ready", 128'(in_ready), 128'd1);
        step("serial_resume");
        chk("serial_resume.const_rs1", 128'(out_rs1), 128'(32'h1234));

        // Output stall, then flush releases a blocked instruction
        idle(); in_valid = 1'b1; in_rd_v = 1'b1; in_rd = 5'd9;
        pl_a = {$urandom, $urandom, $urandom, $urandom}; in_payload = pl_a;
        step("stall_issue");
        idle(); out_ready = 1'b0; in_valid = 1'b1; in_rs1_v = 1'b1; in_rs1_ad = 5'd9;
        for (int k = 0; k < 4; k++) begin
            step("stall_hold");
            chk("stall_hold.const_payload", out_payload, pl_a);
            chk("stall_hold.const_rd", 128'(out_rd), 128'd9);
        end
        flush = 1'b1;
        #1 chk("flush.const_block", 128'(in_ready), 128'd0);
        step("flush");
        chk("flush.const_valid", 128'(out_valid), 128'd0);
        flush = 1'b0;
        #1 chk("post_flush.const_ready", 128'(in_ready), 128'd1);
        step("post_flush");
        chk("post_flush.const_valid", 128'(out_valid), 128'd1);
        idle(); step("drain2");

        // Reset during SERIAL_WAIT with x3 pending
        idle(); in_valid = 1'b1; in_serial = 1'b1; in_rd_v = 1'b1; in_rd = 5'd3;
        in_payload = {$urandom, $urandom, $urandom, $urandom};
        step("pre_rst");
        idle(); out_ready = 1'b0; step("pre_rst_hold");
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst.in_ready", 128'(in_ready), 128'd0);
        chk_out("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        idle(); in_valid = 1'b1; in_rs1_v = 1'b1; in_rs1_ad = 5'd3; in_rd_v = 1'b1; in_rd = 5'd3;
        #1 chk("after_rst.const_ready", 128'(in_ready), 128'd1);
        step("after_rst");

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_rs1_ad = 5'($urandom_range(0, 7));
            in_rs2_ad = 5'($urandom_range(0, 7));
            in_rd = 5'($urandom_range(0, 7));
            in_rs1_v = 1'($urandom_range(0, 1));
            in_rs2_v = 1'($urandom_range(0, 1));
            in_rd_v = 1'($urandom_range(0, 1));
            in_serial = 1'($urandom_range(0, 9) == 0);
            in_payload = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                wb_valid[i] = 1'($urandom_range(0, 2) == 0);
                wb_adr[i*5 +: 5] = 5'($urandom_range(0, 7));
                wb_data[i*32 +: 32] = $urandom;
            end
            serial_done = 1'($urandom_range(0, 3) == 0);
            flush = 1'($urandom_range(0, 40) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_dispatch.md
REGISTER_DISPATCH -- requirements
Module: register_dispatch

Interface
REQ-001 Parameters: XLEN, default 32, datapath width; NREGS, default 32, architectural registers (power of 2, x0 hardwired zero); NWB, default 2, write-back ports; PAYLOAD_W, default 128, opaque decode/pc/immediate payload width; BYPASS, default 1, enables write-back-to-read forwarding.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid/in_ready  in/out  1/1  issue handshake from decode.
REQ-005 in_rs1_ad, in_rs2_ad, in_rd  in  log2(NREGS) each  source and destination addresses.
REQ-006 in_rs1_v, in_rs2_v, in_rd_v  in  1 each  source used / destination written.
REQ-007 in_serial  in  1  instruction serialises the pipe (branch, jalr, mret).
REQ-008 in_payload  in  PAYLOAD_W  carried unchanged to the output.
REQ-009 out_valid/out_ready  out/in  1/1  handshake to the execution units.
REQ-010 out_rs1, out_rs2  out  XLEN each; out_rd  out  log2(NREGS); out_rd_v  out  1; out_payload  out  PAYLOAD_W.
REQ-011 wb_valid  in  NWB; wb_adr  in  NWB*log2(NREGS); wb_data  in  NWB*XLEN  write-back ports.
REQ-012 serial_done  in  1  pulse: serialising instruction resolved.
REQ-013 flush  in  1  discard the staged output and all pending state.

Function
REQ-014 Transfer occurs on valid&&ready at both ports; latency accept to out_valid is exactly 1 cycle.
REQ-015 Scoreboard: one pending bit per register; set on accept when in_rd_v && in_rd!=0; cleared when any wb_valid[i] targets it.
REQ-016 RAW hazard: a used source with pending bit set SHALL block acceptance unless BYPASS=1 and a same-cycle wb port targets that address.
REQ-017 WAW hazard: in_rd_v with pending[in_rd] set (after same-cycle clears) SHALL block acceptance.
REQ-018 in_ready = !flush && state==RUN && no hazard && (!out_valid || out_ready).
REQ-019 Reads of x0 return 0; writes to x0 are ignored; unused sources output 0.
REQ-020 Same-cycle writes to one address from several ports: highest index wins, for both register file and bypass.
REQ-021 Same-cycle clear (wb) and set (accept) on one register: set wins.
REQ-022 FSM RUN/SERIAL_WAIT: accept with in_serial -> SERIAL_WAIT; serial_done -> RUN; flush -> RUN; serial_done in RUN ignored.
REQ-023 Output stage holds all out_* stable while out_valid && !out_ready.
REQ-024 flush: out_valid cleared next cycle, all pending bits cleared, state -> RUN, no acceptance that cycle; register-file writes that same cycle still commit.
REQ-025 Flush has priority over accept, serial_done and output advance.

Reset
REQ-026 On rst: out_valid=0, out_rs1=out_rs2=0, out_rd=0, out_rd_v=0, out_payload=0, all pending=0, state=RUN, all registers=0.
REQ-027 in_ready=0 while rst asserted; operation begins the first edge after deassertion.
REQ-028 rst asserted mid-SERIAL_WAIT or mid-stall returns to the REQ-026 state immediately.

Structure
REQ-029 Shared package holds the FSM state enum, register-address width function and default parameter constants.
REQ-030 One sub-module, regfile_mp: NREGS x XLEN, NWB write ports, 2 read ports, optional bypass; scoreboard, FSM and output stage reside in register_dispatch.

Verification
REQ-031 Write x5=0x1234 via wb0, then issue rs1=x5 -> next cycle out_rs1=0x1234, out_valid=1.
REQ-032 Issue rd=x3, then rs1=x3 -> in_ready=0 until wb1 writes x3=0xBEEF; with BYPASS=1 accepted that same cycle, out_rs1=0xBEEF.
REQ-033 Same-cycle wb0 x7=1, wb1 x7=2 -> later read x7 returns 2; wb to x0 -> x0 reads 0.
REQ-034 Issue in_serial=1 -> in_ready=0 for 3 cycles until serial_done, then acceptance resumes next cycle.
REQ-035 out_ready=0 for 4 cycles with out_valid=1 -> out_* unchanged; flush asserted -> out_valid=0 next cycle, pending cleared, previously blocked instruction accepted.
REQ-036 rst asserted during SERIAL_WAIT with x3 pending -> all outputs 0, state RUN, x3 not pending after release.
